// File: rtl/dds_phase_accum.sv
// DDS phase accumulator: byte-wise shadow/commit tuning registers, wrapping accumulator, registered phase.
// Optional PHASE_DITHER_EN adds a 16-bit Galois LFSR dither ahead of phase truncation.
module dds_phase_accum #(
    parameter int ACC_W   = 24,
    parameter int PHASE_W = 14,
    parameter int REG_AW  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               wr_stb,
    input  logic [REG_AW-1:0]  wr_addr,
    input  logic [7:0]         wr_data,
    input  logic               commit,
    input  logic               sync_clr,
    output logic [PHASE_W-1:0] phase_out,
    output logic               wrap,
    output logic               pending
);

    localparam int FTW_EXT_W = (ACC_W > 24) ? ACC_W : 24;
    localparam int OFF_EXT_W = (PHASE_W > 16) ? PHASE_W : 16;

    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     ftw_shadow, ftw_active, ftw_shadow_next;
    logic [PHASE_W-1:0]   off_shadow, off_active, off_shadow_next;
    logic [FTW_EXT_W-1:0] ftw_ext;
    logic [OFF_EXT_W-1:0] off_ext;
    logic                 wr_valid;
    logic [ACC_W:0]       acc_sum;
    logic [ACC_W-1:0]     phase_src;

    // Byte merge of the incoming write; the commit path reads the merged value so a
    // same-cycle write is forwarded into the active registers.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        ftw_ext  = FTW_EXT_W'(ftw_shadow);
        off_ext  = OFF_EXT_W'(off_shadow);
        wr_valid = 1'b0;
        if (wr_stb) begin
            case (wr_addr)
                REG_AW'(0): begin ftw_ext[7:0]   = wr_data; wr_valid = 1'b1; end
                REG_AW'(1): begin ftw_ext[15:8]  = wr_data; wr_valid = 1'b1; end
                REG_AW'(2): begin ftw_ext[23:16] = wr_data; wr_valid = 1'b1; end
                REG_AW'(3): begin off_ext[7:0]   = wr_data; wr_valid = 1'b1; end
                REG_AW'(4): begin off_ext[15:8]  = wr_data; wr_valid = 1'b1; end
                default: ;
            endcase
        end
        ftw_shadow_next = ftw_ext[ACC_W-1:0];
        off_shadow_next = off_ext[PHASE_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ftw_shadow <= '0;
            off_shadow <= '0;
            ftw_active <= '0;
            off_active <= '0;
            pending    <= 1'b0;
        end else begin
            ftw_shadow <= ftw_shadow_next;
            off_shadow <= off_shadow_next;
            if (commit) begin
                ftw_active <= ftw_shadow_next;
                off_active <= off_shadow_next;
                pending    <= 1'b0;
            end else if (wr_valid) begin
                pending    <= 1'b1;
            end
        end
    end

    assign acc_sum = {1'b0, acc} + {1'b0, ftw_active};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            wrap      <= 1'b0;
            phase_out <= '0;
        end else begin
            if (sync_clr) begin
                acc  <= '0;
                wrap <= 1'b0;
            end else if (ena) begin
                acc  <= acc_sum[ACC_W-1:0];
                wrap <= acc_sum[ACC_W];
            end else begin
                wrap <= 1'b0;
            end
            // Phase is taken from the registered accumulator, hence the one-cycle lag.
            phase_out <= phase_src[ACC_W-1 -: PHASE_W] + off_active;
        end
    end

`ifdef PHASE_DITHER_EN
    localparam int DITHER_W = ACC_W - PHASE_W;

    logic [15:0]      lfsr;
    logic [ACC_W-1:0] dither;

    always_comb begin
        dither = '0;
        for (int i = 0; i < DITHER_W && i < 16; i++) dither[i] = lfsr[i];
    end

    // Dither only perturbs the truncation point; the carry out of the sum is dropped.
    assign phase_src = acc + dither;

    // Galois form of x^16+x^14+x^13+x^11+1 (right shift, toggle mask 0xB400).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   lfsr <= 16'hACE1;
        else if (ena) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
`else
    assign phase_src = acc;
`endif

endmodule
